// File: rtl/iic_proxy_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// iic_proxy_arbiter_pkg
// Shared definitions for the IIC proxy arbiter slice: FSM state encoding,
// read/write direction constants and default field widths.
// ---------------------------------------------------------------------------
package iic_proxy_arbiter_pkg;

   localparam int DEV_W_DEF  = 7;
   localparam int REG_W_DEF  = 8;
   localparam int DATA_W_DEF = 8;

   localparam logic IIC_RW_READ  = 1'b1;
   localparam logic IIC_RW_WRITE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

endpackage : iic_proxy_arbiter_pkg

// File: rtl/iic_proxy_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin pick. A lone requester always wins; when
// both request, the one that did not win last time is granted.
// Ports:
//   valid_i       request vector, bit i = requester i
//   last_grant_i  index of the previous winner
//   grant_o       one-hot grant, 0 when nobody requests
// ---------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

   // NOTE: grant_o gets a default before the case so no latch can be inferred.
   always_comb begin
      grant_o = 2'b00;
      case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule : rr_arbiter2

// File: rtl/iic_proxy_arbiter.sv
// ---------------------------------------------------------------------------
// iic_proxy_arbiter
// Shares one IIC proxy transaction port between two requesters. Whole
// transactions are serialised (one start, then wait for done) with a
// round-robin pick, and a watchdog aborts transactions the proxy never ends.
// Ports:
//   in_clk, in_rst         clock, asynchronous active-high reset
//   in_req_*               per-requester request and fields (packed, i*W)
//   out_req_done/err/rdata completion pulse, error flag, shared read data
//   out_grant              one-hot current owner
//   out_px_*               start pulse and registered fields to the proxy
//   in_px_*                proxy busy/done/nack/read data
// ---------------------------------------------------------------------------
module iic_proxy_arbiter
   import iic_proxy_arbiter_pkg::*;
#(
   parameter int DEV_W          = DEV_W_DEF,
   parameter int REG_W          = REG_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                in_clk,
   input  logic                in_rst,
   input  logic [1:0]          in_req_valid,
   input  logic [1:0]          in_req_rw,
   input  logic [2*DEV_W-1:0]  in_req_dev,
   input  logic [2*REG_W-1:0]  in_req_reg,
   input  logic [2*DATA_W-1:0] in_req_wdata,
   output logic [1:0]          out_req_done,
   output logic [1:0]          out_req_err,
   output logic [DATA_W-1:0]   out_req_rdata,
   output logic [1:0]          out_grant,
   output logic                out_px_start,
   output logic                out_px_rw,
   output logic [DEV_W-1:0]    out_px_dev,
   output logic [REG_W-1:0]    out_px_reg,
   output logic [DATA_W-1:0]   out_px_wdata,
   input  logic                in_px_busy,
   input  logic                in_px_done,
   input  logic                in_px_nack,
   input  logic [DATA_W-1:0]   in_px_rdata
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   // The abort decision is taken while the timer holds TIMEOUT_CYCLES-2; the
   // timer lands on TIMEOUT_CYCLES-1 with the move to RESP, so the done pulse
   // appears exactly TIMEOUT_CYCLES cycles after the start pulse.
   localparam logic [TMR_W-1:0] TMR_ABORT = TMR_W'(TIMEOUT_CYCLES - 2);
   localparam logic [TMR_W-1:0] TMR_MAX   = '1;

   arb_state_e          state_q, state_d;
   logic [1:0]          grant_q, grant_d;
   logic                last_grant_q, last_grant_d;
   logic                rw_q, rw_d;
   logic [DEV_W-1:0]    dev_q, dev_d;
   logic [REG_W-1:0]    reg_q, reg_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [TMR_W-1:0]    timer_q, timer_d;

   logic [1:0]          pick;
   logic                win_idx;

   rr_arbiter2 u_rr (
      .valid_i      (in_req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (pick)
   );

   assign win_idx = pick[1];

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      rw_d         = rw_q;
      dev_d        = dev_q;
      reg_d        = reg_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      timer_d      = timer_q;

      case (state_q)
         ST_IDLE: begin
            if (|in_req_valid) begin
               grant_d      = pick;
               last_grant_d = win_idx;
               rw_d         = in_req_rw[win_idx];
               dev_d        = in_req_dev[win_idx*DEV_W +: DEV_W];
               reg_d        = in_req_reg[win_idx*REG_W +: REG_W];
               wdata_d      = in_req_wdata[win_idx*DATA_W +: DATA_W];
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!in_px_busy) begin
               timer_d = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (timer_q != TMR_MAX) begin
               timer_d = timer_q + 1'b1;
            end
            // A proxy completion in the abort cycle still counts as a real
            // completion, so done is tested first.
            if (in_px_done) begin
               err_d   = in_px_nack;
               rdata_d = (rw_q == IIC_RW_READ) ? in_px_rdata : '0;
               state_d = ST_RESP;
            end else if (timer_q == TMR_ABORT) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            grant_d = 2'b00;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values computed above.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= 2'b00;
         last_grant_q <= 1'b1;
         rw_q         <= 1'b0;
         dev_q        <= '0;
         reg_q        <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         rw_q         <= rw_d;
         dev_q        <= dev_d;
         reg_q        <= reg_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         timer_q      <= timer_d;
      end
   end

   // Start and done are decoded from state so that an asynchronous reset
   // clears them in the same cycle along with the registers.
   assign out_px_start  = (state_q == ST_ISSUE) && !in_px_busy;
   assign out_req_done  = (state_q == ST_RESP) ? grant_q : 2'b00;
   assign out_req_err   = out_req_done & {2{err_q}};
   assign out_req_rdata = rdata_q;
   assign out_grant     = grant_q;
   assign out_px_rw     = rw_q;
   assign out_px_dev    = dev_q;
   assign out_px_reg    = reg_q;
   assign out_px_wdata  = wdata_q;

endmodule : iic_proxy_arbiter

// File: tb/tb_iic_proxy_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iic_proxy_arbiter
// Directed and randomized transactions against a transaction-level model:
// the model knows who should win, when the response is due (done delay + 1 or
// the timeout length after the start pulse) and what done/err/rdata must be.
// ---------------------------------------------------------------------------
module tb_iic_proxy_arbiter;

   localparam int DEV_W  = 7;
   localparam int REG_W  = 8;
   localparam int DATA_W = 8;
   localparam int TO     = 24;

   logic                in_clk;
   logic                in_rst;
   logic [1:0]          in_req_valid;
   logic [1:0]          in_req_rw;
   logic [2*DEV_W-1:0]  in_req_dev;
   logic [2*REG_W-1:0]  in_req_reg;
   logic [2*DATA_W-1:0] in_req_wdata;
   logic [1:0]          out_req_done;
   logic [1:0]          out_req_err;
   logic [DATA_W-1:0]   out_req_rdata;
   logic [1:0]          out_grant;
   logic                out_px_start;
   logic                out_px_rw;
   logic [DEV_W-1:0]    out_px_dev;
   logic [REG_W-1:0]    out_px_reg;
   logic [DATA_W-1:0]   out_px_wdata;
   logic                in_px_busy;
   logic                in_px_done;
   logic                in_px_nack;
   logic [DATA_W-1:0]   in_px_rdata;

   iic_proxy_arbiter #(
      .DEV_W          (DEV_W),
      .REG_W          (REG_W),
      .DATA_W         (DATA_W),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .in_clk        (in_clk),
      .in_rst        (in_rst),
      .in_req_valid  (in_req_valid),
      .in_req_rw     (in_req_rw),
      .in_req_dev    (in_req_dev),
      .in_req_reg    (in_req_reg),
      .in_req_wdata  (in_req_wdata),
      .out_req_done  (out_req_done),
      .out_req_err   (out_req_err),
      .out_req_rdata (out_req_rdata),
      .out_grant     (out_grant),
      .out_px_start  (out_px_start),
      .out_px_rw     (out_px_rw),
      .out_px_dev    (out_px_dev),
      .out_px_reg    (out_px_reg),
      .out_px_wdata  (out_px_wdata),
      .in_px_busy    (in_px_busy),
      .in_px_done    (in_px_done),
      .in_px_nack    (in_px_nack),
      .in_px_rdata   (in_px_rdata)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   int vectors     = 0;
   int miscompares = 0;
   int starts      = 0;

   // Model state
   logic [1:0]        pend;
   int                last;
   logic              f_rw  [2];
   logic [DEV_W-1:0]  f_dev [2];
   logic [REG_W-1:0]  f_reg [2];
   logic [DATA_W-1:0] f_wd  [2];

   always @(negedge in_clk) if (out_px_start === 1'b1) starts++;

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, observed run still active, required finish");
      $fatal(1, "bench time limit");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({out_req_done, out_req_err, out_req_rdata, out_grant, out_px_start,
                  out_px_rw, out_px_dev, out_px_reg, out_px_wdata});
   endfunction

   task automatic set_req(input int i, input logic rw, input logic [DEV_W-1:0] dev,
                          input logic [REG_W-1:0] rg, input logic [DATA_W-1:0] wd);
      f_rw[i] = rw; f_dev[i] = dev; f_reg[i] = rg; f_wd[i] = wd;
      in_req_rw[i]                      = rw;
      in_req_dev[i*DEV_W +: DEV_W]      = dev;
      in_req_reg[i*REG_W +: REG_W]      = rg;
      in_req_wdata[i*DATA_W +: DATA_W]  = wd;
   endtask

   task automatic check_fields(input string tag, input int w);
      check({tag, "_rw"},  out_px_rw,    f_rw[w]);
      check({tag, "_dev"}, out_px_dev,   f_dev[w]);
      check({tag, "_reg"}, out_px_reg,   f_reg[w]);
      check({tag, "_wd"},  out_px_wdata, f_wd[w]);
   endtask

   task automatic apply_reset();
      in_rst = 1'b1;
      in_req_valid = 2'b00;
      in_px_busy = 1'b0; in_px_done = 1'b0; in_px_nack = 1'b0; in_px_rdata = '0;
      pend = 2'b00;
      last = 1;
      repeat (2) @(posedge in_clk);
      #1;
      check("reset_outputs", all_outs(), 64'd0);
      in_rst = 1'b0;
      @(negedge in_clk);
   endtask

   // One whole transaction. Called in an IDLE cycle; returns in the IDLE cycle
   // after RESP. dly>=1: proxy done dly cycles after start; dly<0: never.
   task automatic do_txn(input logic [1:0] add, input int busy_cyc, input int dly,
                         input logic nack, input logic [DATA_W-1:0] prd, input bit drop_mid);
      int w, resp_cyc, s0;
      logic [1:0] oh;
      logic exp_err;
      logic [DATA_W-1:0] exp_rd;
      pend = pend | add;
      in_req_valid = pend;
      in_px_busy = (busy_cyc > 0);
      w  = (pend == 2'b11) ? 1 - last : (pend[1] ? 1 : 0);
      oh = 2'b01 << w;
      last = w;
      s0 = starts;
      @(posedge in_clk); #1;
      for (int b = 0; b < busy_cyc; b++) begin
         in_px_done = (b == 0);   // stray completion while not waiting
         @(negedge in_clk);
         check("grant_busy", out_grant, oh);
         check("start_busy", out_px_start, 1'b0);
         check_fields("fields_busy", w);
         @(posedge in_clk); #1;
         in_px_done = 1'b0;
      end
      in_px_busy = 1'b0;
      @(negedge in_clk);
      check("grant", out_grant, oh);
      check("start", out_px_start, 1'b1);
      check_fields("fields_start", w);
      @(posedge in_clk); #1;
      if (drop_mid) begin
         pend[w] = 1'b0;
         in_req_valid = pend;
      end
      resp_cyc = (dly >= 1) ? dly + 1 : TO;
      for (int k = 1; k < resp_cyc; k++) begin
         if (k == dly) begin
            in_px_done = 1'b1; in_px_nack = nack; in_px_rdata = prd;
         end
         @(negedge in_clk);
         check("no_done_wait", out_req_done, 2'b00);
         check("no_start_wait", out_px_start, 1'b0);
         @(posedge in_clk); #1;
         in_px_done = 1'b0; in_px_nack = 1'b0; in_px_rdata = DATA_W'($urandom);
      end
      exp_err = (dly >= 1) ? nack : 1'b1;
      exp_rd  = (dly >= 1 && f_rw[w]) ? prd : '0;
      @(negedge in_clk);
      check("resp_done",  out_req_done,  oh);
      check("resp_err",   out_req_err,   exp_err ? oh : 2'b00);
      check("resp_rdata", out_req_rdata, exp_rd);
      check("resp_grant", out_grant,     oh);
      check("one_start",  starts - s0,   1);
      check_fields("fields_resp", w);
      @(posedge in_clk); #1;
      pend[w] = 1'b0;
      in_req_valid = pend;
      @(negedge in_clk);
      check("idle_grant", out_grant,     2'b00);
      check("idle_done",  out_req_done,  2'b00);
      check("idle_rdata", out_req_rdata, exp_rd);
   endtask

   initial begin
      int s0;
      logic [1:0] add;
      in_req_rw = '0; in_req_dev = '0; in_req_reg = '0; in_req_wdata = '0;
      f_rw = '{default: 1'b0}; f_dev = '{default: '0};
      f_reg = '{default: '0};  f_wd = '{default: '0};
      apply_reset();

      // Req0 write, proxy idle, done 20 cycles after start
      set_req(0, 1'b0, 7'h50, 8'h10, 8'hA5);
      do_txn(2'b01, 0, 20, 1'b0, 8'h77, 1'b0);

      // Both valid after reset: req0 then req1, two starts
      apply_reset();
      set_req(0, 1'b0, 7'h21, 8'h02, 8'h11);
      set_req(1, 1'b1, 7'h42, 8'h03, 8'h22);
      s0 = starts;
      do_txn(2'b11, 0, 3, 1'b0, 8'h5A, 1'b0);
      do_txn(2'b00, 0, 4, 1'b0, 8'h6B, 1'b0);
      check("two_starts", starts - s0, 2);

      // Req1 read with nack
      set_req(1, 1'b1, 7'h33, 8'h44, 8'h00);
      do_txn(2'b10, 0, 7, 1'b1, 8'h3C, 1'b0);

      // Watchdog abort, then done landing exactly in the abort cycle
      set_req(0, 1'b1, 7'h15, 8'h25, 8'h35);
      do_txn(2'b01, 0, -1, 1'b0, 8'h00, 1'b0);
      set_req(0, 1'b1, 7'h16, 8'h26, 8'h36);
      do_txn(2'b01, 0, TO - 1, 1'b0, 8'h9D, 1'b0);

      // Proxy busy for 5 cycles after grant, requester drops valid mid-flight
      set_req(1, 1'b0, 7'h7F, 8'hFF, 8'hC3);
      do_txn(2'b10, 5, 2, 1'b1, 8'h00, 1'b1);

      // Proxy done while idle is ignored
      in_px_done = 1'b1; in_px_nack = 1'b1;
      @(posedge in_clk); #1;
      in_px_done = 1'b0; in_px_nack = 1'b0;
      @(negedge in_clk);
      check("idle_px_done", {out_req_done, out_grant}, 4'b0000);

      // Reset in the middle of WAIT
      set_req(0, 1'b0, 7'h0A, 8'h0B, 8'h0C);
      in_req_valid = 2'b01;
      repeat (5) @(posedge in_clk);
      #1;
      in_rst = 1'b1;
      #1;
      check("rst_mid_wait", all_outs(), 64'd0);
      in_req_valid = 2'b00;
      @(posedge in_clk); #1;
      in_rst = 1'b0;
      pend = 2'b00; last = 1;
      in_px_done = 1'b1;
      @(posedge in_clk); #1;
      in_px_done = 1'b0;
      @(negedge in_clk);
      check("late_done", {out_req_done, out_grant}, 4'b0000);
      set_req(1, 1'b1, 7'h61, 8'h62, 8'h63);
      do_txn(2'b11, 1, 5, 1'b0, 8'hE1, 1'b0);
      do_txn(2'b00, 0, 6, 1'b0, 8'hE2, 1'b0);

      // Randomized transactions
      for (int it = 0; it < 30; it++) begin
         add = 2'($urandom);
         if ((pend | add) == 2'b00) add = 2'b01 << $urandom_range(1, 0);
         for (int i = 0; i < 2; i++) begin
            if (add[i] && !pend[i])
               set_req(i, 1'($urandom), DEV_W'($urandom), REG_W'($urandom), DATA_W'($urandom));
         end
         do_txn(add, $urandom_range(3, 0),
                ($urandom_range(7, 0) == 0) ? -1 : $urandom_range(TO - 1, 1),
                1'($urandom), DATA_W'($urandom), ($urandom_range(3, 0) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_iic_proxy_arbiter
